// File: rtl/qpu_event_timing_queue_if.sv
// Handshake bundle between the QIU write-back stage, the event queue and the
// analog/waveform interface: push channel in, issue channel out.
interface qpu_event_timing_queue_if #(
    parameter int EVENT_WIRE_WIDTH = 64,
    parameter int EVENT_NUM        = 10,
    parameter int TQGL_WIDTH       = 24,
    parameter int TIME_WIDTH       = 32
);
    logic                        eq_i_valid;
    logic                        eq_i_ready;
    logic [EVENT_WIRE_WIDTH-1:0] eq_i_edata;
    logic [EVENT_NUM-1:0]        eq_i_oprand;
    logic [TQGL_WIDTH-1:0]       eq_i_tqgl;
    logic [TIME_WIDTH-1:0]       eq_i_tdata;

    logic                        evt_o_valid;
    logic [EVENT_WIRE_WIDTH-1:0] evt_o_edata;
    logic [EVENT_NUM-1:0]        evt_o_oprand;
    logic [TQGL_WIDTH-1:0]       evt_o_tqgl;
    logic                        evt_o_late;

    modport master (
        output eq_i_valid, eq_i_edata, eq_i_oprand, eq_i_tqgl, eq_i_tdata,
        input  eq_i_ready,
        input  evt_o_valid, evt_o_edata, evt_o_oprand, evt_o_tqgl, evt_o_late
    );

    modport slave (
        input  eq_i_valid, eq_i_edata, eq_i_oprand, eq_i_tqgl, eq_i_tdata,
        output eq_i_ready,
        output evt_o_valid, evt_o_edata, evt_o_oprand, evt_o_tqgl, evt_o_late
    );
endinterface

// File: rtl/qpu_event_timing_queue.sv
// Timestamped event FIFO: holds write-back bundles in order and releases the
// head exactly when the free-running QPU timer reaches its timestamp.
module qpu_event_timing_queue #(
    parameter int EVENT_WIRE_WIDTH = 64,
    parameter int EVENT_NUM        = 10,
    parameter int TQGL_WIDTH       = 24,
    parameter int TIME_WIDTH       = 32,
    parameter int DEPTH            = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       timer_en,
    input  logic                       timer_clr,
    input  logic                       flush,
    input  logic                       late_err_clr,
    qpu_event_timing_queue_if.slave    eq_if,
    output logic                       late_err,
    output logic [TIME_WIDTH-1:0]      timer_o,
    output logic [$clog2(DEPTH):0]     eq_o_count,
    output logic                       eq_o_empty,
    output logic                       eq_o_full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    typedef struct packed {
        logic [TIME_WIDTH-1:0]       tdata;
        logic [EVENT_WIRE_WIDTH-1:0] edata;
        logic [EVENT_NUM-1:0]        oprand;
        logic [TQGL_WIDTH-1:0]       tqgl;
    } entry_t;

    entry_t                mem_q [DEPTH];
    entry_t                mem_d [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]        count_q, count_d;
    logic [TIME_WIDTH-1:0] timer_q, timer_d;
    logic                  late_err_q, late_err_d;

    entry_t                head;
    entry_t                in_entry;
    logic [TIME_WIDTH-1:0] diff;
    logic                  empty, full, ready, push, pop, is_late;

    // Wrap-safe lateness: a negative (MSB set) distance to the head timestamp means late.
    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == FULL_COUNT);
        head     = mem_q[rd_ptr_q];
        diff     = head.tdata - timer_q;
        is_late  = diff[TIME_WIDTH-1];
        ready    = ~full & ~flush;
        push     = eq_if.eq_i_valid & ready;
        pop      = rst_n & ~empty & timer_en & ~flush & ((diff == '0) | is_late);
        in_entry = '{tdata:  eq_if.eq_i_tdata,
                     edata:  eq_if.eq_i_edata,
                     oprand: eq_if.eq_i_oprand,
                     tqgl:   eq_if.eq_i_tqgl};
    end

    always_comb begin
        timer_d    = timer_q;
        late_err_d = late_err_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        mem_d      = mem_q;

        if (timer_clr) begin
            timer_d = '0;
        end else if (timer_en) begin
            timer_d = timer_q + 1'b1;
        end

        if (pop & is_late) begin
            late_err_d = 1'b1;
        end else if (late_err_clr) begin
            late_err_d = 1'b0;
        end

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = in_entry;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timer_q    <= '0;
            late_err_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            timer_q    <= timer_d;
            late_err_q <= late_err_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Payload storage needs no reset; outputs are masked whenever the queue is empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        eq_if.eq_i_ready   = ready;
        eq_if.evt_o_valid  = pop;
        eq_if.evt_o_late   = pop & is_late;
        eq_if.evt_o_edata  = empty ? '0 : head.edata;
        eq_if.evt_o_oprand = empty ? '0 : head.oprand;
        eq_if.evt_o_tqgl   = empty ? '0 : head.tqgl;
        late_err           = late_err_q;
        timer_o            = timer_q;
        eq_o_count         = count_q;
        eq_o_empty         = empty;
        eq_o_full          = full;
    end
endmodule

// File: tb/tb_qpu_event_timing_queue.sv
// Randomized and directed bench for qpu_event_timing_queue, built with an 8-bit
// timer so wrap-around is reachable; expectations come from a queue-based model.
module tb_qpu_event_timing_queue;
    localparam int EW    = 64;
    localparam int EN    = 10;
    localparam int TQ    = 24;
    localparam int TW    = 8;
    localparam int DEPTH = 8;

    typedef struct {
        logic [TW-1:0] tdata;
        logic [EW-1:0] edata;
        logic [EN-1:0] oprand;
        logic [TQ-1:0] tqgl;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          timer_en = 1'b0;
    logic          timer_clr = 1'b0;
    logic          flush = 1'b0;
    logic          late_err_clr = 1'b0;
    logic          late_err;
    logic [TW-1:0] timer_o;
    logic [3:0]    eq_o_count;
    logic          eq_o_empty;
    logic          eq_o_full;

    int            tests_run = 0;
    int            failures = 0;
    int            issue_seen = 0;
    int            late_seen = 0;
    logic [TW-1:0] issue_times[$];

    ev_t           model_q[$];
    logic [TW-1:0] m_timer = '0;
    logic          m_late_err = 1'b0;

    qpu_event_timing_queue_if #(
        .EVENT_WIRE_WIDTH(EW), .EVENT_NUM(EN), .TQGL_WIDTH(TQ), .TIME_WIDTH(TW)
    ) eq_if ();

    qpu_event_timing_queue #(
        .EVENT_WIRE_WIDTH(EW), .EVENT_NUM(EN), .TQGL_WIDTH(TQ),
        .TIME_WIDTH(TW), .DEPTH(DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .timer_en    (timer_en),
        .timer_clr   (timer_clr),
        .flush       (flush),
        .late_err_clr(late_err_clr),
        .eq_if       (eq_if),
        .late_err    (late_err),
        .timer_o     (timer_o),
        .eq_o_count  (eq_o_count),
        .eq_o_empty  (eq_o_empty),
        .eq_o_full   (eq_o_full)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        tests_run++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // One clock cycle: compare against the model mid-cycle, then advance the model at the edge.
    task automatic step();
        ev_t           head;
        logic [TW-1:0] diff;
        bit            e_valid, e_late, e_ready;
        int            n;
        @(negedge clk);
        n    = model_q.size();
        head = '{tdata: '0, edata: '0, oprand: '0, tqgl: '0};
        if (n > 0) head = model_q[0];
        diff    = head.tdata - m_timer;
        e_valid = rst_n && (n > 0) && timer_en && !flush && (diff == 0 || diff[TW-1]);
        e_late  = e_valid && diff[TW-1];
        e_ready = (n < DEPTH) && !flush;
        checkOutput("evt_o_valid",  64'(eq_if.evt_o_valid),  64'(e_valid));
        checkOutput("evt_o_late",   64'(eq_if.evt_o_late),   64'(e_late));
        checkOutput("evt_o_edata",  64'(eq_if.evt_o_edata),  64'(head.edata));
        checkOutput("evt_o_oprand", 64'(eq_if.evt_o_oprand), 64'(head.oprand));
        checkOutput("evt_o_tqgl",   64'(eq_if.evt_o_tqgl),   64'(head.tqgl));
        checkOutput("eq_i_ready",   64'(eq_if.eq_i_ready),   64'(e_ready));
        checkOutput("eq_o_count",   64'(eq_o_count),         64'(n));
        checkOutput("eq_o_empty",   64'(eq_o_empty),         64'(n == 0));
        checkOutput("eq_o_full",    64'(eq_o_full),          64'(n == DEPTH));
        checkOutput("timer_o",      64'(timer_o),            64'(m_timer));
        checkOutput("late_err",     64'(late_err),           64'(m_late_err));
        if (eq_if.evt_o_valid === 1'b1) begin
            issue_seen++;
            issue_times.push_back(timer_o);
            if (eq_if.evt_o_late === 1'b1) late_seen++;
        end
        @(posedge clk);
        if (!rst_n) begin
            model_q.delete();
            m_timer    = '0;
            m_late_err = 1'b0;
        end else begin
            if (timer_clr) m_timer = '0;
            else if (timer_en) m_timer = m_timer + 8'd1;
            if (e_late) m_late_err = 1'b1;
            else if (late_err_clr) m_late_err = 1'b0;
            if (flush) begin
                model_q.delete();
            end else begin
                if (e_valid) void'(model_q.pop_front());
                if (eq_if.eq_i_valid && e_ready)
                    model_q.push_back('{tdata: eq_if.eq_i_tdata, edata: eq_if.eq_i_edata,
                                        oprand: eq_if.eq_i_oprand, tqgl: eq_if.eq_i_tqgl});
            end
        end
        #1;
    endtask

    task automatic applyStimulus(input bit valid, input logic [TW-1:0] tdata, input bit en,
                                 input bit clr, input bit fl, input bit lclr);
        eq_if.eq_i_valid  = valid;
        eq_if.eq_i_tdata  = tdata;
        eq_if.eq_i_edata  = {$urandom, $urandom};
        eq_if.eq_i_oprand = EN'($urandom);
        eq_if.eq_i_tqgl   = TQ'($urandom);
        timer_en          = en;
        timer_clr         = clr;
        flush             = fl;
        late_err_clr      = lclr;
        step();
    endtask

    task automatic clearIssueLog();
        issue_seen = 0;
        late_seen  = 0;
        issue_times.delete();
    endtask

    initial begin
        logic [TW-1:0] td;
        eq_if.eq_i_valid  = 1'b0;
        eq_if.eq_i_tdata  = '0;
        eq_if.eq_i_edata  = '0;
        eq_if.eq_i_oprand = '0;
        eq_if.eq_i_tqgl   = '0;
        repeat (2) @(posedge clk);
        #1;
        applyStimulus(0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        // On-time issue of three future timestamps.
        clearIssueLog();
        applyStimulus(1, 8'd5, 1, 0, 0, 0);
        applyStimulus(1, 8'd9, 1, 0, 0, 0);
        applyStimulus(1, 8'd20, 1, 0, 0, 0);
        repeat (22) applyStimulus(0, 0, 1, 0, 0, 0);
        checkOutput("t1_issues", 64'(issue_seen), 64'd3);
        checkOutput("t1_late", 64'(late_seen), 64'd0);
        checkOutput("t1_time0", 64'(issue_times[0]), 64'd5);
        checkOutput("t1_time1", 64'(issue_times[1]), 64'd9);
        checkOutput("t1_time2", 64'(issue_times[2]), 64'd20);
        checkOutput("t1_count", 64'(eq_o_count), 64'd0);

        // Fill with the timer frozen, then drain back-to-back.
        applyStimulus(0, 0, 0, 1, 0, 0);
        repeat (DEPTH) applyStimulus(1, 8'd0, 0, 0, 0, 0);
        checkOutput("t2_full", 64'(eq_o_full), 64'd1);
        checkOutput("t2_ready", 64'(eq_if.eq_i_ready), 64'd0);
        applyStimulus(1, 8'd0, 0, 0, 0, 0);
        checkOutput("t2_count9", 64'(eq_o_count), 64'(DEPTH));
        clearIssueLog();
        repeat (DEPTH + 2) applyStimulus(0, 0, 1, 0, 0, 0);
        checkOutput("t2_issues", 64'(issue_seen), 64'(DEPTH));
        checkOutput("t2_late", 64'(late_seen), 64'(DEPTH - 1));
        checkOutput("t2_late_err", 64'(late_err), 64'd1);
        applyStimulus(0, 0, 1, 0, 0, 1);
        checkOutput("t2_late_err_clr", 64'(late_err), 64'd0);

        // Stale timestamp issues next cycle as late.
        applyStimulus(0, 0, 1, 1, 0, 0);
        repeat (100) applyStimulus(0, 0, 1, 0, 0, 0);
        clearIssueLog();
        applyStimulus(1, 8'd50, 1, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 0);
        checkOutput("t3_late_issue", 64'(late_seen), 64'd1);
        checkOutput("t3_late_err", 64'(late_err), 64'd1);
        applyStimulus(0, 0, 1, 0, 0, 1);

        // Timestamp beyond the wrap point must wait for the wrap.
        applyStimulus(0, 0, 1, 1, 0, 0);
        repeat (254) applyStimulus(0, 0, 1, 0, 0, 0);
        clearIssueLog();
        applyStimulus(1, 8'd1, 1, 0, 0, 0);
        repeat (5) applyStimulus(0, 0, 1, 0, 0, 0);
        checkOutput("t4_issues", 64'(issue_seen), 64'd1);
        checkOutput("t4_time", 64'(issue_times[0]), 64'd1);
        checkOutput("t4_late", 64'(late_seen), 64'd0);

        // Flush with due head and a concurrent push.
        td = m_timer;
        repeat (3) applyStimulus(1, td, 0, 0, 0, 0);
        clearIssueLog();
        applyStimulus(1, td, 1, 0, 1, 0);
        checkOutput("t5_count", 64'(eq_o_count), 64'd0);
        checkOutput("t5_empty", 64'(eq_o_empty), 64'd1);
        checkOutput("t5_issues", 64'(issue_seen), 64'd0);

        // Reset while issuing with four entries pending.
        applyStimulus(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(1, 8'(i), 0, 0, 0, 0);
        clearIssueLog();
        applyStimulus(0, 0, 1, 0, 0, 0);
        checkOutput("t6_count4", 64'(eq_o_count), 64'd4);
        rst_n = 1'b0;
        applyStimulus(1, 8'd1, 1, 0, 0, 0);
        rst_n = 1'b1;
        checkOutput("t6_timer", 64'(timer_o), 64'd0);
        checkOutput("t6_empty", 64'(eq_o_empty), 64'd1);
        repeat (8) applyStimulus(0, 0, 1, 0, 0, 0);
        checkOutput("t6_issues", 64'(issue_seen), 64'd1);

        // Randomized traffic around the current timer.
        for (int i = 0; i < 600; i++) begin
            td = m_timer + 8'($urandom_range(0, 35)) - 8'd5;
            applyStimulus(($urandom % 3) != 0, td, ($urandom % 8) != 0,
                          ($urandom % 64) == 0, ($urandom % 50) == 0, ($urandom % 16) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end
endmodule
